// File: rtl/credit_pkg.sv
// Shared types and helpers for the credit-based link sender.
// The optional stall statistics (CREDIT_TX_STATS_EN) use the counter type and limit defined here.
package credit_pkg;

    typedef logic [31:0] stall_cnt_t;

    localparam stall_cnt_t STALL_MAX = 32'hFFFF_FFFF;

    // Enough bits to hold every value from 0 up to and including depth.
    function automatic int credit_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a sticky error flag.
// The error flag is raised when a credit is returned while the counter is already full.
module credit_counter
    import credit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = credit_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // A simultaneous inc and dec cancel out, so only the one-sided cases touch the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= FULL;
            overflow <= 1'b0;
        end else if (dec && !inc) begin
            if (count != '0)
                count <= count - ONE;
        end else if (inc && !dec) begin
            if (count == FULL)
                overflow <= 1'b1;
            else
                count <= count + ONE;
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/credit_tx.sv
// Credit-throttled sender: ready/valid in, registered valid-only word out.
// Optional stall statistics are enabled with CREDIT_TX_STATS_EN.
module credit_tx
    import credit_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CNT_W = credit_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_bits,
    input  logic             credit_return,
    output logic [CNT_W-1:0] credits,
    output logic             credit_err
`ifdef CREDIT_TX_STATS_EN
    ,
    output stall_cnt_t       stall_cycles
`endif
);

    logic fire;
    logic has_credit;

    // in_ready depends only on the counter, so a same-cycle return cannot unblock it.
    assign in_ready = has_credit;
    assign fire     = in_valid & in_ready;

    credit_counter #(
        .DEPTH(DEPTH)
    ) u_credit_counter (
        .clk      (clk),
        .reset    (reset),
        .inc      (credit_return),
        .dec      (fire),
        .count    (credits),
        .nonzero  (has_credit),
        .overflow (credit_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid <= 1'b0;
            tx_bits  <= '0;
        end else begin
            tx_valid <= fire;
            if (fire)
                tx_bits <= in_bits;
        end
    end

`ifdef CREDIT_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles <= '0;
        else if (in_valid && !in_ready && stall_cycles != STALL_MAX)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
